clb_param: RTL and testbench

- Parametrised successor to the fixed 4-input, two-output configurable logic block.
- Provides NUM_LUTS independent LUT slices, each with a LUT_INPUTS-input truth table, an optional output register and an optional feedback path.
- Adds programmable set, reset and clock-enable per slice.
- Configuration is loaded at runtime over a serial shift chain with a bit counter and load-state machine, so tiles can be daisy-chained into a fabric.

---
 rtl/clb_param.sv | 164 ++++++++++++++++
 tb/tb_clb_param.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clb_param.sv
// clb_param: parametrised configurable logic block tile.
//
// NUM_LUTS independent slices, each holding a 2^LUT_INPUTS-entry truth table,
// an output select (combinational LUT or flop), a feedback select (replace the
// top LUT input with the slice flop) and a 2-bit SR mode (none / set / clear /
// clock-enable). Configuration is shifted in serially, LSB end first out, so
// tiles can be daisy-chained through CFG_IN -> CFG_OUT.
//
// Ports:
//   K        clock, rising edge
//   RST      synchronous active-high reset
//   I        LUT inputs, slice n uses I[n*LUT_INPUTS +: LUT_INPUTS]
//   SR       per-slice set/reset/enable pin, meaning chosen by SRMODE
//   CFG_EN   shift enable for the config chain
//   CFG_IN   serial config data in
//   CFG_OUT  serial config data out (bit about to be shifted out)
//   CFG_DONE high while the block is configured (ACTIVE)
//   O        slice outputs, forced to 0 unless ACTIVE
//
// Slice n occupies cfg[n*SLICE_BITS +: SLICE_BITS]:
//   [TT_BITS-1:0] truth table, [TT_BITS] OSEL, [TT_BITS+1] FBSEL,
//   [TT_BITS+3:TT_BITS+2] SRMODE.
module clb_param #(
  parameter int LUT_INPUTS = 4,
  parameter int NUM_LUTS   = 2
) (
  input  logic                           K,
  input  logic                           RST,
  input  logic [NUM_LUTS*LUT_INPUTS-1:0] I,
  input  logic [NUM_LUTS-1:0]            SR,
  input  logic                           CFG_EN,
  input  logic                           CFG_IN,
  output logic                           CFG_OUT,
  output logic                           CFG_DONE,
  output logic [NUM_LUTS-1:0]            O
);

  localparam int TT_BITS    = 1 << LUT_INPUTS;
  localparam int SLICE_BITS = TT_BITS + 4;
  localparam int CFG_BITS   = NUM_LUTS * SLICE_BITS;
  localparam int CNT_W      = $clog2(CFG_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CFG_BITS - 1);

  typedef enum logic [1:0] {
    UNCFG   = 2'd0,
    LOADING = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [CFG_BITS-1:0]  cfg;
  logic [NUM_LUTS-1:0]  q;
  logic                 active;
  logic                 run;

  // Config shift register: new bits enter at the top, cfg[0] leaves first.
  always_ff @(posedge K) begin
    if (RST) begin
      cfg <= '0;
    end else if (CFG_EN) begin
      cfg <= {CFG_IN, cfg[CFG_BITS-1:1]};
    end
  end

  assign CFG_OUT = cfg[0];

  // Load-state machine: state register.
  always_ff @(posedge K) begin
    if (RST) begin
      state <= UNCFG;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Load-state machine: next state. The counter tracks shifts already taken,
  // so the shift that finds LAST_CNT is the final bit of the chain.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      UNCFG: begin
        if (CFG_EN) begin
          state_nxt = LOADING;
          cnt_nxt   = CNT_W'(1);
        end
      end
      LOADING: begin
        if (CFG_EN) begin
          if (cnt == LAST_CNT) begin
            state_nxt = ACTIVE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      ACTIVE: begin
        if (CFG_EN) begin
          state_nxt = LOADING;
          cnt_nxt   = CNT_W'(1);
        end
      end
      default: begin
        state_nxt = UNCFG;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign active   = (state == ACTIVE);
  assign CFG_DONE = active;
  // Flops only evolve while the block stays ACTIVE; an edge that leaves
  // ACTIVE (reconfiguration) clears them like any non-ACTIVE edge.
  assign run      = active && !CFG_EN;

  for (genvar n = 0; n < NUM_LUTS; n++) begin : g_slice
    logic [TT_BITS-1:0]    tt;
    logic                  osel;
    logic                  fbsel;
    logic [1:0]            srmode;
    logic [LUT_INPUTS-1:0] idx;
    logic                  lut;
    logic                  q_r;

    assign tt     = cfg[n*SLICE_BITS +: TT_BITS];
    assign osel   = cfg[n*SLICE_BITS + TT_BITS];
    assign fbsel  = cfg[n*SLICE_BITS + TT_BITS + 1];
    assign srmode = cfg[n*SLICE_BITS + TT_BITS + 2 +: 2];

    // Feedback replaces the top LUT input with last cycle's flop value.
    always_comb begin
      idx = I[n*LUT_INPUTS +: LUT_INPUTS];
      if (fbsel) begin
        idx[LUT_INPUTS-1] = q_r;
      end
    end

    assign lut = tt[idx];

    always_ff @(posedge K) begin
      if (RST) begin
        q_r <= 1'b0;
      end else if (!run) begin
        q_r <= 1'b0;
      end else if (srmode == 2'b10 && SR[n]) begin
        q_r <= 1'b0;
      end else if (srmode == 2'b01 && SR[n]) begin
        q_r <= 1'b1;
      end else if (srmode == 2'b11 && !SR[n]) begin
        q_r <= q_r;
      end else begin
        q_r <= lut;
      end
    end

    assign q[n] = q_r;
    assign O[n] = active & (osel ? q_r : lut);
  end

endmodule

// File: tb/tb_clb_param.sv
// Self-checking bench for clb_param with LUT_INPUTS=4, NUM_LUTS=2 (40-bit chain).
// Inputs are driven 1 time unit after a rising edge and outputs sampled 1 unit
// later. Expected {CFG_DONE, O} values are pushed onto exp_q when stimulus is
// applied and popped/compared once the DUT output is due.
module tb_clb_param;

  localparam int LUT_INPUTS = 4;
  localparam int NUM_LUTS   = 2;
  localparam int CFG_BITS   = 40;

  logic                           K;
  logic                           RST;
  logic [NUM_LUTS*LUT_INPUTS-1:0] I;
  logic [NUM_LUTS-1:0]            SR;
  logic                           CFG_EN;
  logic                           CFG_IN;
  logic                           CFG_OUT;
  logic                           CFG_DONE;
  logic [NUM_LUTS-1:0]            O;

  clb_param #(
    .LUT_INPUTS(LUT_INPUTS),
    .NUM_LUTS  (NUM_LUTS)
  ) dut (
    .K       (K),
    .RST     (RST),
    .I       (I),
    .SR      (SR),
    .CFG_EN  (CFG_EN),
    .CFG_IN  (CFG_IN),
    .CFG_OUT (CFG_OUT),
    .CFG_DONE(CFG_DONE),
    .O       (O)
  );

  // Clock / reset block
  initial begin
    K = 1'b0;
    forever #5 K = ~K;
  end

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected {CFG_DONE, O[1], O[0]}
  logic [2:0] exp_q[$];
  string      name_q[$];

  typedef struct {
    logic [3:0] code;
    logic       exp_o0;
  } comb_vec_t;

  comb_vec_t comb_tbl[16];

  function automatic logic [19:0] slice_cfg(input logic [15:0] tt, input logic osel,
                                            input logic fbsel, input logic [1:0] srmode);
    return {srmode, fbsel, osel, tt};
  endfunction

  task automatic step();
    @(posedge K);
    #1;
  endtask

  task automatic push_exp(input string name, input logic [2:0] v);
    exp_q.push_back(v);
    name_q.push_back(name);
  endtask

  task automatic pop_check();
    logic [2:0] e;
    string      n;
    logic [2:0] act;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry for actual %b", {CFG_DONE, O});
    end else begin
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      act = {CFG_DONE, O};
      if (act !== e) begin
        errors++;
        $display("FAIL %s: actual {done,O}=%b expected %b at %0t", n, act, e, $time);
      end
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic shift_bit(input logic b);
    CFG_EN = 1'b1;
    CFG_IN = b;
    step();
    CFG_EN = 1'b0;
    CFG_IN = 1'b0;
  endtask

  // Shifts bits [n-1:0] of v, bit 0 first, so a full load leaves v in cfg.
  task automatic load_bits(input logic [39:0] v, input int n);
    for (int b = 0; b < n; b++) shift_bit(v[b]);
  endtask

  logic [39:0] cfg_a, cfg_b, cfg_c, cfg_d, pat;

  initial begin
    RST    = 1'b1;
    I      = '0;
    SR     = '0;
    CFG_EN = 1'b0;
    CFG_IN = 1'b0;

    cfg_a = {slice_cfg(16'h0000, 1'b0, 1'b0, 2'b00), slice_cfg(16'h0116, 1'b0, 1'b0, 2'b00)};
    cfg_b = {slice_cfg(16'h00FF, 1'b1, 1'b1, 2'b00), slice_cfg(16'h0000, 1'b0, 1'b0, 2'b00)};
    cfg_c = {slice_cfg(16'h0000, 1'b1, 1'b0, 2'b01), slice_cfg(16'hFFFF, 1'b1, 1'b0, 2'b10)};
    cfg_d = {slice_cfg(16'h0000, 1'b0, 1'b0, 2'b00), slice_cfg(16'h00FF, 1'b1, 1'b1, 2'b11)};
    pat   = 40'hA5_F0F0_1234;

    // TT 0x0116 is true exactly for one-hot input codes.
    for (int c = 0; c < 16; c++) begin
      comb_tbl[c].code   = 4'(c);
      comb_tbl[c].exp_o0 = ($countones(4'(c)) == 1);
    end

    // Reset held for two edges with inputs toggling.
    for (int r = 0; r < 2; r++) begin
      I  = 8'($urandom_range(0, 255));
      SR = 2'($urandom_range(0, 3));
      step();
      push_exp("reset_out", 3'b000);
      pop_check();
      chk_bit("reset_cfg_out", CFG_OUT, 1'b0);
    end
    RST = 1'b0;

    // 39 shifts leave the block unconfigured; the 40th completes it.
    I = 8'h01;
    load_bits(cfg_a, 39);
    push_exp("after_39_shifts", 3'b000);
    pop_check();
    shift_bit(cfg_a[39]);
    push_exp("after_40_shifts", 3'b101);
    pop_check();

    // Combinational LUT: table-driven over all 16 codes.
    for (int v = 0; v < 16; v++) begin
      I = {4'($urandom_range(0, 15)), comb_tbl[v].code};
      push_exp($sformatf("comb_code_%0d", v), {1'b1, 1'b0, comb_tbl[v].exp_o0});
      pop_check();
      step();
    end

    // Registered toggle via feedback on slice 1.
    load_bits(cfg_b, CFG_BITS);
    I = 8'($urandom_range(0, 255));
    push_exp("toggle_initial", 3'b100);
    pop_check();
    for (int e = 0; e < 6; e++) begin
      push_exp($sformatf("toggle_edge_%0d", e), {1'b1, (e % 2 == 0) ? 1'b1 : 1'b0, 1'b0});
      step();
      pop_check();
    end

    // SR clear (slice 0, TT all ones) and SR set (slice 1, TT all zeros).
    load_bits(cfg_c, CFG_BITS);
    push_exp("sr_initial", 3'b100);
    pop_check();
    SR = 2'b11;
    for (int e = 0; e < 3; e++) begin
      push_exp($sformatf("sr_active_%0d", e), 3'b110);
      step();
      pop_check();
    end
    SR = 2'b00;
    push_exp("sr_released", 3'b101);
    step();
    pop_check();

    // SR as clock enable on a toggling slice 0.
    load_bits(cfg_d, CFG_BITS);
    SR = 2'b00;
    for (int e = 0; e < 4; e++) begin
      push_exp($sformatf("ce_frozen_%0d", e), 3'b100);
      step();
      pop_check();
    end
    SR = 2'b01;
    push_exp("ce_enabled_1", 3'b101);
    step();
    pop_check();
    push_exp("ce_enabled_2", 3'b100);
    step();
    pop_check();
    SR = 2'b00;

    // Chain passthrough: pattern reappears on CFG_OUT 40 shifts later.
    load_bits(pat, CFG_BITS);
    for (int k = 0; k < CFG_BITS; k++) begin
      chk_bit($sformatf("chain_bit_%0d", k), CFG_OUT, pat[k]);
      shift_bit(1'b0);
    end
    push_exp("chain_done_zero_cfg", 3'b100);
    pop_check();

    // Reconfiguration pulse drops CFG_DONE and O on the next edge.
    load_bits(cfg_a, CFG_BITS);
    I = 8'h01;
    push_exp("reconfig_before", 3'b101);
    pop_check();
    shift_bit(1'b0);
    push_exp("reconfig_after_pulse", 3'b000);
    pop_check();

    // Reset on the 20th shift of a reload wins over CFG_EN.
    RST = 1'b1;
    step();
    RST = 1'b0;
    load_bits(cfg_a, 19);
    RST    = 1'b1;
    CFG_EN = 1'b1;
    CFG_IN = cfg_a[19];
    step();
    RST    = 1'b0;
    CFG_EN = 1'b0;
    chk_bit("mid_reset_cfg_out", CFG_OUT, 1'b0);
    push_exp("mid_reset_out", 3'b000);
    pop_check();
    load_bits(cfg_a, 39);
    push_exp("reload_39_shifts", 3'b000);
    pop_check();
    shift_bit(cfg_a[39]);
    I = 8'h08;
    push_exp("reload_code_8", 3'b101);
    pop_check();
    I = 8'h03;
    push_exp("reload_code_3", 3'b100);
    pop_check();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: actual %0d entries expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
